// File: rtl/cache_ctrl_nway.sv
// N-way set-associative, write-through/no-allocate cache controller with 2-word lines.
// Reads hit combinationally; misses fill a whole line from SRAM, and replacement is age-based LRU.
module cache_ctrl_nway #(
    parameter int WAYS   = 2,
    parameter int SETS   = 64,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              sram_rd,
    output logic              sram_wr,
    output logic [ADDR_W-3:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [63:0]       sram_rdata,
    input  logic              sram_ready
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 3 - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, READ_MISS, WRITE} state_t;

    state_t state, state_nx;

    logic             valid_q [SETS][WAYS];
    logic [WAY_W-1:0] age_q   [SETS][WAYS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [63:0]      data_q  [SETS][WAYS];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             offset;
    logic             unused_addr;

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [63:0]      hit_line;
    logic [31:0]      hit_word;
    logic [WAY_W-1:0] victim;
    logic             found;

    logic             fill;
    logic             word_wr;
    logic             touch;
    logic [WAY_W-1:0] touch_way;

    assign idx         = addr[3 +: IDX_W];
    assign tag         = addr[ADDR_W-1 -: TAG_W];
    assign offset      = addr[2];
    assign unused_addr = ^addr[1:0];

    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        hit_line = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!hit && valid_q[idx][i] && tag_q[idx][i] == tag) begin
                hit      = 1'b1;
                hit_way  = WAY_W'(i);
                hit_line = data_q[idx][i];
            end
        end
        hit_word = offset ? hit_line[63:32] : hit_line[31:0];
    end

    // Lowest-index invalid way wins; otherwise the oldest (age == WAYS-1).
    always_comb begin
        victim = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (age_q[idx][i] == WAY_W'(WAYS - 1))
                victim = WAY_W'(i);
        end
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!found && !valid_q[idx][i]) begin
                victim = WAY_W'(i);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        ready      = 1'b0;
        rdata      = '0;
        sram_rd    = 1'b0;
        sram_wr    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        fill       = 1'b0;
        word_wr    = 1'b0;
        touch      = 1'b0;
        touch_way  = hit_way;
        case (state)
            IDLE: begin
                if (MEM_W_EN) begin
                    state_nx = WRITE;
                end else if (MEM_R_EN) begin
                    if (hit) begin
                        ready = 1'b1;
                        rdata = hit_word;
                        touch = 1'b1;
                    end else begin
                        state_nx = READ_MISS;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            READ_MISS: begin
                sram_rd   = 1'b1;
                sram_addr = {addr[ADDR_W-1:3], 1'b0};
                if (sram_ready) begin
                    fill      = 1'b1;
                    touch     = 1'b1;
                    touch_way = victim;
                    state_nx  = IDLE;
                end
            end
            WRITE: begin
                sram_wr    = 1'b1;
                sram_addr  = addr[ADDR_W-1:2];
                sram_wdata = wdata;
                if (sram_ready) begin
                    ready    = 1'b1;
                    state_nx = IDLE;
                    if (hit) begin
                        word_wr = 1'b1;
                        touch   = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            if (fill)
                valid_q[idx][victim] <= 1'b1;
            if (touch) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == touch_way)
                        age_q[idx][w] <= '0;
                    else if (age_q[idx][w] < age_q[idx][touch_way])
                        age_q[idx][w] <= age_q[idx][w] + WAY_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[idx][victim]  <= tag;
            data_q[idx][victim] <= sram_rdata;
        end
        if (word_wr) begin
            if (offset)
                data_q[idx][hit_way][63:32] <= wdata;
            else
                data_q[idx][hit_way][31:0] <= wdata;
        end
    end

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Directed bench for cache_ctrl_nway: behavioural SRAM with fixed latency plus a read-data scoreboard.
module tb_cache_ctrl_nway;

    localparam int AW  = 19;
    localparam int LAT = 3;

    logic          clk;
    logic          rst;
    logic          MEM_R_EN;
    logic          MEM_W_EN;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ready;
    logic          sram_rd;
    logic          sram_wr;
    logic [AW-3:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [63:0]   sram_rdata;
    logic          sram_ready;
    logic          auto_ready;
    logic          man_ready;
    logic          auto_en;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        hit;
    } sb_t;
    sb_t sb_q[$];

    logic [31:0] ref_mem  [logic [16:0]];
    logic [31:0] sram_mem [logic [16:0]];

    assign sram_ready = auto_ready | man_ready;

    cache_ctrl_nway #(.WAYS(2), .SETS(64), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (MEM_R_EN),
        .MEM_W_EN   (MEM_W_EN),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .sram_rd    (sram_rd),
        .sram_wr    (sram_wr),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_ready (sram_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] dflt(input logic [16:0] w);
        return {~w[15:0], w[15:0]};
    endfunction

    function automatic logic [31:0] ref_word(input logic [16:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : dflt(w);
    endfunction

    function automatic logic [31:0] sram_word(input logic [16:0] w);
        return sram_mem.exists(w) ? sram_mem[w] : dflt(w);
    endfunction

    // SRAM model: completes a held request on its LAT-th cycle with a one-cycle pulse.
    initial begin
        int unsigned cnt;
        cnt        = 0;
        auto_ready = 1'b0;
        sram_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            auto_ready = 1'b0;
            if (auto_en && rst && (sram_rd || sram_wr)) begin
                cnt++;
                if (cnt == LAT) begin
                    cnt        = 0;
                    auto_ready = 1'b1;
                    if (sram_rd)
                        sram_rdata = {sram_word(sram_addr | 17'd1), sram_word(sram_addr & ~17'd1)};
                    else
                        sram_mem[sram_addr] = sram_wdata;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic exp_hit, input string tag);
        sb_t          e;
        logic         saw_rd, saw_wr, addr_bad;
        logic [16:0]  ea;
        int unsigned  cycles;
        ea = {a[AW-1:3], 1'b0};
        sb_q.push_back('{data: ref_word(a[AW-1:2]), hit: exp_hit});
        @(posedge clk);
        #1;
        addr     = a;
        MEM_R_EN = 1'b1;
        saw_rd   = 1'b0;
        saw_wr   = 1'b0;
        addr_bad = 1'b0;
        cycles   = 0;
        do begin
            @(negedge clk);
            if (sram_rd) begin
                saw_rd = 1'b1;
                if (sram_addr !== ea) addr_bad = 1'b1;
            end
            if (sram_wr) saw_wr = 1'b1;
            if (!ready) cycles++;
        end while (!ready && cycles < 40);
        e = sb_q.pop_front();
        check({tag, "_ready"}, ready, 1);
        check({tag, "_latency"}, cycles, e.hit ? 0 : LAT + 1);
        check({tag, "_rdata"}, rdata, e.data);
        check({tag, "_sram_rd"}, saw_rd, !e.hit);
        check({tag, "_sram_addr"}, addr_bad, 0);
        check({tag, "_no_wr"}, saw_wr, 0);
        @(posedge clk);
        #1;
        MEM_R_EN = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic both,
                            input string tag);
        logic        saw_rd, saw_wr, bad;
        int unsigned cycles;
        ref_mem[a[AW-1:2]] = d;
        @(posedge clk);
        #1;
        addr     = a;
        wdata    = d;
        MEM_W_EN = 1'b1;
        MEM_R_EN = both;
        saw_rd   = 1'b0;
        saw_wr   = 1'b0;
        bad      = 1'b0;
        cycles   = 0;
        do begin
            @(negedge clk);
            if (sram_wr) begin
                saw_wr = 1'b1;
                if (sram_addr !== a[AW-1:2] || sram_wdata !== d) bad = 1'b1;
            end
            if (sram_rd) saw_rd = 1'b1;
            if (!ready) cycles++;
        end while (!ready && cycles < 40);
        check({tag, "_ready"}, ready, 1);
        check({tag, "_latency"}, cycles, LAT);
        check({tag, "_sram_wr"}, saw_wr, 1);
        check({tag, "_wr_addr_data"}, bad, 0);
        check({tag, "_no_rd"}, saw_rd, 0);
        @(posedge clk);
        #1;
        MEM_W_EN = 1'b0;
        MEM_R_EN = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        MEM_R_EN  = 1'b0;
        MEM_W_EN  = 1'b0;
        addr      = '0;
        wdata     = '0;
        man_ready = 1'b0;
        auto_en   = 1'b1;
        ref_mem[17'd4]  = 32'h1111_1111;
        ref_mem[17'd5]  = 32'h2222_2222;
        sram_mem[17'd4] = 32'h1111_1111;
        sram_mem[17'd5] = 32'h2222_2222;

        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_sram_rd", sram_rd, 0);
        check("rst_sram_wr", sram_wr, 0);
        check("rst_sram_addr", sram_addr, 0);
        check("rst_sram_wdata", sram_wdata, 0);
        check("rst_rdata", rdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        do_read(19'h00010, 1'b0, "cold_read");
        do_read(19'h00014, 1'b1, "odd_word_hit");

        do_read(19'h00000, 1'b0, "set0_a");
        do_read(19'h00200, 1'b0, "set0_b");
        do_read(19'h00000, 1'b1, "set0_a_hit");
        do_read(19'h00400, 1'b0, "set0_c_evict_b");
        do_read(19'h00000, 1'b1, "set0_a_kept");
        do_read(19'h00200, 1'b0, "set0_b_evicted");

        do_write(19'h00010, 32'hDEAD_BEEF, 1'b0, "write_hit");
        do_read(19'h00010, 1'b1, "read_after_write");
        do_read(19'h00014, 1'b1, "other_word_intact");
        do_write(19'h01000, 32'hCAFE_F00D, 1'b0, "write_miss");
        do_read(19'h01000, 1'b0, "write_miss_no_fill");

        // Abandon a read miss by reset, then feed a stray completion pulse in IDLE.
        @(posedge clk);
        #1;
        auto_en  = 1'b0;
        addr     = 19'h00030;
        MEM_R_EN = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("miss_pending_sram_rd", sram_rd, 1);
        #1;
        rst      = 1'b0;
        MEM_R_EN = 1'b0;
        #1;
        check("midmiss_rst_ready", ready, 1);
        check("midmiss_rst_sram_rd", sram_rd, 0);
        check("midmiss_rst_sram_addr", sram_addr, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        man_ready = 1'b1;
        @(negedge clk);
        check("stray_ready_ready", ready, 1);
        check("stray_ready_sram_rd", sram_rd, 0);
        check("stray_ready_sram_wr", sram_wr, 0);
        @(posedge clk);
        #1;
        man_ready = 1'b0;
        auto_en   = 1'b1;
        do_read(19'h00030, 1'b0, "after_rst_miss");
        do_read(19'h00010, 1'b0, "after_rst_invalid");

        do_write(19'h00014, 32'h55AA_55AA, 1'b1, "both_enables");
        do_read(19'h00014, 1'b1, "both_enables_readback");

        check("scoreboard_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
